bg_fade_draw: RTL
=================

Name: bg_fade_draw

Overview:
- Parametrised successor to the single-colour background renderer.
- Produces an RGB332 background pixel per game state (welcome/play/game-over), with a fixed-colour border frame and black outside the visible area.
- State changes cross-fade linearly over 2^FADE_LOG2 frames, one step per frame.
- Sits in the VGA pixel path, feeding the lowest-priority layer of the object mux.

Parameters:
- X_FRAME, 639, last visible pixelX.
- Y_FRAME, 479, last visible pixelY.
- BORDER_W, 10, border thickness in pixels; 0 disables the border.
- BORDER_RGB, 8'hFF, border colour (RGB332).
- FADE_LOG2, 3, log2 of fade length in frames; range 0..4, where 0 means an instant switch.
- PAL0, 8'b000_100_00, welcome colour.
- PAL1, 8'b100_000_00, play colour.
- PAL2, 8'b000_000_10, game-over colour.
- PAL3, 8'b000_000_10, colour for bgState 2'b11.

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse at the start of each frame
- bgState  in  2  requested background state
- pixelX  in  11  current pixel column
- pixelY  in  11  current pixel row
- BG_RGB  out  8  background pixel {R[2:0],G[2:0],B[1:0]}
- fadeBusy  out  1  high while a fade is in progress

Behaviour:
- Reset (async, resetN=0):
  - BG_RGB=8'h00, fadeBusy=0.
  - tgtState=2'b00, fromRGB=PAL0, step=0, FSM=IDLE.
  - curRGB=PAL0.
- FSM states: IDLE, FADE.
- IDLE:
  - curRGB = PAL[tgtState].
  - If bgState != tgtState: fromRGB <= curRGB, tgtState <= bgState, step <= 0, go to FADE.
  - If FADE_LOG2=0: curRGB jumps to the new palette entry on the next cycle and the FSM stays in IDLE.
- FADE:
  - fadeBusy=1.
  - Each startOfFrame: step <= step+1.
  - When step+1 == 2^FADE_LOG2: go to IDLE. curRGB then equals PAL[tgtState] exactly.
  - If bgState changes mid-fade (bgState != tgtState): restart. fromRGB <= current blended curRGB, tgtState <= bgState, step <= 0. There is no visible jump.
  - If a bgState change and startOfFrame arrive in the same cycle, the restart wins and that pulse is not counted.
- Blend arithmetic, per channel (R 3b, G 3b, B 2b):
  - d = signed(to - from), width+1 bits.
  - chan = from + ((d * step) >>> FADE_LOG2), with an arithmetic (floor) shift.
  - The result is clamped to the channel range.
  - curRGB is a register updated only on a startOfFrame or restart cycle, so there is no mid-frame tearing.
- Pixel output, registered with 1-cycle latency from pixelX/pixelY:
  - pixelX > X_FRAME or pixelY > Y_FRAME: 8'h00.
  - Else, if BORDER_W > 0 and (pixelX < BORDER_W or pixelX > X_FRAME-BORDER_W or pixelY < BORDER_W or pixelY > Y_FRAME-BORDER_W): BORDER_RGB.
  - Else: curRGB.
- Reset asserted mid-fade aborts the fade immediately. After release the block starts in IDLE showing PAL0 (welcome). If bgState != 0 at that point, a fresh fade begins.
- bgState is sampled every cycle; it is assumed synchronous to clk.

Test Plan:
- Reset, then bgState=0, pixel (320,240) -> BG_RGB=8'h00 during reset; 8'b000_100_00 one cycle after the first post-reset pixel; fadeBusy=0.
- bgState 0->1, then 4 startOfFrame pulses (FADE_LOG2=3), pixel (320,240) -> R=2, G=2, B=0, i.e. 8'b010_010_00. After 8 pulses: 8'b100_000_00 and fadeBusy=0.
- Border check, BORDER_W=10: pixel (9,100) -> 8'hFF; (10,100) -> curRGB; (630,100) -> 8'hFF; (629,100) -> curRGB; (640,100) -> 8'h00; (100,480) -> 8'h00.
- Mid-fade redirect: fade 0->1, 4 pulses in (curRGB=8'b010_010_00), then bgState=2 in the same cycle as startOfFrame -> step=0, output stays 8'b010_010_00. After 8 further pulses: 8'b000_000_10.
- resetN pulsed low mid-fade (step=5) -> BG_RGB=8'h00 immediately (async). After release with bgState=1: fade restarts from PAL0, fadeBusy=1.
- FADE_LOG2=0 build: bgState 0->2 -> output is 8'b000_000_10 two cycles later and fadeBusy never asserts.

Source files
------------

// File: rtl/bg_fade_draw.sv
// Background layer for the VGA object mux: per-state RGB332 fill with a border
// frame, cross-fading linearly between state colours one step per frame.
module bg_fade_draw #(
  parameter int          X_FRAME    = 639,
  parameter int          Y_FRAME    = 479,
  parameter int          BORDER_W   = 10,
  parameter logic [7:0]  BORDER_RGB = 8'hFF,
  parameter int          FADE_LOG2  = 3,
  parameter logic [7:0]  PAL0       = 8'b000_100_00,
  parameter logic [7:0]  PAL1       = 8'b100_000_00,
  parameter logic [7:0]  PAL2       = 8'b000_000_10,
  parameter logic [7:0]  PAL3       = 8'b000_000_10
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [1:0]  bgState,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic [7:0]  BG_RGB,
  output logic        fadeBusy
);

  localparam logic [4:0]  FADE_LEN = 5'(1 << FADE_LOG2);
  localparam logic [10:0] XF       = 11'(X_FRAME);
  localparam logic [10:0] YF       = 11'(Y_FRAME);
  localparam logic [10:0] BW       = 11'(BORDER_W);
  localparam logic [10:0] XB       = 11'(X_FRAME - BORDER_W);
  localparam logic [10:0] YB       = 11'(Y_FRAME - BORDER_W);

  typedef enum logic {IDLE, FADE} state_t;

  state_t      state, nxt_state;
  logic [1:0]  tgt, nxt_tgt;
  logic [7:0]  from_rgb, nxt_from;
  logic [7:0]  cur_rgb, nxt_cur;
  logic [4:0]  step, nxt_step, step_inc;
  logic        in_vis, on_border;

  function automatic logic [7:0] pal(input logic [1:0] s);
    case (s)
      2'd0:    pal = PAL0;
      2'd1:    pal = PAL1;
      2'd2:    pal = PAL2;
      default: pal = PAL3;
    endcase
  endfunction

  // from + floor(d*step / 2^FADE_LOG2), clamped to the channel range
  function automatic int chan(input int f, input int t, input int s, input int maxv);
    int d, p, r;
    d = t - f;
    p = (d * s) >>> FADE_LOG2;
    r = f + p;
    if (r < 0)    r = 0;
    if (r > maxv) r = maxv;
    return r;
  endfunction

  function automatic logic [7:0] blend(input logic [7:0] f, input logic [7:0] t,
                                       input logic [4:0] s);
    blend = {3'(chan(int'(f[7:5]), int'(t[7:5]), int'(s), 7)),
             3'(chan(int'(f[4:2]), int'(t[4:2]), int'(s), 7)),
             2'(chan(int'(f[1:0]), int'(t[1:0]), int'(s), 3))};
  endfunction

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else         state <= nxt_state;

  always_comb begin
    nxt_state = state;
    nxt_tgt   = tgt;
    nxt_from  = from_rgb;
    nxt_step  = step;
    nxt_cur   = cur_rgb;
    step_inc  = step + 5'd1;
    fadeBusy  = (state == FADE);
    case (state)
      IDLE: begin
        nxt_cur = pal(tgt);
        if (bgState != tgt) begin
          nxt_tgt = bgState;
          if (FADE_LOG2 == 0) begin
            nxt_cur = pal(bgState);
          end else begin
            nxt_from  = cur_rgb;
            nxt_step  = 5'd0;
            nxt_cur   = cur_rgb;
            nxt_state = FADE;
          end
        end
      end
      FADE: begin
        // a redirect restarts from the colour on screen, so nothing jumps
        if (bgState != tgt) begin
          nxt_from = cur_rgb;
          nxt_tgt  = bgState;
          nxt_step = 5'd0;
        end else if (startOfFrame) begin
          nxt_step = step_inc;
          nxt_cur  = blend(from_rgb, pal(tgt), step_inc);
          if (step_inc == FADE_LEN) nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      tgt      <= 2'd0;
      from_rgb <= PAL0;
      cur_rgb  <= PAL0;
      step     <= 5'd0;
    end else begin
      tgt      <= nxt_tgt;
      from_rgb <= nxt_from;
      cur_rgb  <= nxt_cur;
      step     <= nxt_step;
    end

  always_comb begin
    in_vis    = (pixelX <= XF) && (pixelY <= YF);
    on_border = (BORDER_W > 0) &&
                ((pixelX < BW) || (pixelX > XB) || (pixelY < BW) || (pixelY > YB));
  end

  always_ff @(posedge clk or negedge resetN)
    if (!resetN)        BG_RGB <= 8'h00;
    else if (!in_vis)   BG_RGB <= 8'h00;
    else if (on_border) BG_RGB <= BORDER_RGB;
    else                BG_RGB <= cur_rgb;

endmodule
